// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: ramps the duty cycle of a downstream pwm instance toward a
// commanded target, one step every dwell PWM periods, always on period
// boundaries.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   cmd_valid/ready    fade command handshake (ready only while IDLE)
//   cmd_divval         pwm clock divider value
//   cmd_maxcnt         pwm timer max count (clamped to 0xFFFE)
//   cmd_target         target duty in timer ticks (clamped to maxcnt+1)
//   cmd_step           duty increment per update (0 treated as 1)
//   cmd_dwell          PWM periods between updates (0 treated as 1)
//   abort              stop the ramp and hold the current duty
//   config_out         {maxcnt, divval} for pwm config_in
//   comp_levels_out    {hpoint, lpoint} for pwm comp_levels_in
//   busy               high while ramping
//   done               one-cycle pulse when the target is reached
module pwm_fade_ctrl #(
   parameter int unsigned CNT_W = 34
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_divval,
   input  logic [15:0] cmd_maxcnt,
   input  logic [15:0] cmd_target,
   input  logic [15:0] cmd_step,
   input  logic [15:0] cmd_dwell,
   input  logic        abort,
   output logic [31:0] config_out,
   output logic [31:0] comp_levels_out,
   output logic        busy,
   output logic        done
);

   localparam int unsigned DW = 16;

   typedef enum logic {IDLE, RAMP} state_t;

   state_t           state;
   logic [DW-1:0]    cur_duty;
   logic [DW-1:0]    maxcnt_l;
   logic [DW-1:0]    target_l;
   logic [DW-1:0]    step_l;
   logic [DW-1:0]    dwell_l;
   logic [DW-1:0]    dwell_cnt;
   logic [CNT_W-1:0] period_last;
   logic [CNT_W-1:0] period_cnt;

   logic [DW-1:0]    acc_maxcnt;
   logic [DW:0]      acc_full;
   logic [DW-1:0]    acc_target;
   logic [DW-1:0]    acc_step;
   logic [DW-1:0]    acc_dwell;
   logic [CNT_W-1:0] acc_period_last;
   logic [DW:0]      sum17;
   logic [DW:0]      diff17;
   logic [DW-1:0]    nxt_duty;
   logic             period_wrap;
   logic             upd_edge;
   logic             final_upd;

   // {hpoint, lpoint} for a duty value; 0 and maxcnt+1 use the never-high /
   // never-low encodings of the pwm comparator.
   function automatic logic [31:0] encode_duty(input logic [DW-1:0] d,
                                               input logic [DW-1:0] mc);
      logic [31:0] r;
      if (d == '0)
         r = {16'hFFFF, 16'h0000};
      else if ({1'b0, d} == ({1'b0, mc} + 17'd1))
         r = {16'h0000, 16'hFFFF};
      else
         r = {16'h0000, d};
      return r;
   endfunction

   // Command clamping, period length and next-duty computation.
   always_comb begin
      acc_maxcnt      = (cmd_maxcnt == 16'hFFFF) ? 16'hFFFE : cmd_maxcnt;
      acc_full        = {1'b0, acc_maxcnt} + 17'd1;
      acc_target      = ({1'b0, cmd_target} > acc_full) ? acc_full[DW-1:0] : cmd_target;
      acc_step        = (cmd_step == '0) ? 16'd1 : cmd_step;
      acc_dwell       = (cmd_dwell == '0) ? 16'd1 : cmd_dwell;
      acc_period_last = (((CNT_W'(cmd_divval) + CNT_W'(1)) *
                          (CNT_W'(acc_maxcnt) + CNT_W'(1))) << 1) - CNT_W'(1);

      // 17-bit arithmetic so the step can never wrap past the target.
      sum17    = {1'b0, cur_duty} + {1'b0, step_l};
      diff17   = {1'b0, cur_duty} - {1'b0, target_l};
      nxt_duty = cur_duty;
      if (target_l > cur_duty) begin
         if (sum17 >= {1'b0, target_l}) nxt_duty = target_l;
         else                           nxt_duty = sum17[DW-1:0];
      end else begin
         if (diff17 <= {1'b0, step_l})  nxt_duty = target_l;
         else                           nxt_duty = cur_duty - step_l;
      end

      period_wrap = (period_cnt == period_last);
      upd_edge    = period_wrap && (dwell_cnt == (dwell_l - 16'd1));
      final_upd   = upd_edge && (nxt_duty == target_l);
   end

   // Sequencer: command accept, period/dwell counting, duty updates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         cmd_ready       <= 1'b1;
         busy            <= 1'b0;
         done            <= 1'b0;
         config_out      <= 32'h0000_0000;
         comp_levels_out <= 32'hFFFF_0000;
         cur_duty        <= '0;
         maxcnt_l        <= '0;
         target_l        <= '0;
         step_l          <= 16'd1;
         dwell_l         <= 16'd1;
         dwell_cnt       <= '0;
         period_last     <= '0;
         period_cnt      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  maxcnt_l    <= acc_maxcnt;
                  target_l    <= acc_target;
                  step_l      <= acc_step;
                  dwell_l     <= acc_dwell;
                  period_last <= acc_period_last;
                  config_out  <= {acc_maxcnt, cmd_divval};
                  period_cnt  <= '0;
                  dwell_cnt   <= '0;
                  if (acc_target == cur_duty) begin
                     done <= 1'b1;
                  end else begin
                     state     <= RAMP;
                     busy      <= 1'b1;
                     cmd_ready <= 1'b0;
                  end
               end
            end
            RAMP: begin
               // Completion takes priority over a coincident abort.
               if (final_upd) begin
                  cur_duty        <= nxt_duty;
                  comp_levels_out <= encode_duty(nxt_duty, maxcnt_l);
                  done            <= 1'b1;
                  state           <= IDLE;
                  busy            <= 1'b0;
                  cmd_ready       <= 1'b1;
               end else if (abort) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
               end else if (period_wrap) begin
                  period_cnt <= '0;
                  if (upd_edge) begin
                     dwell_cnt       <= '0;
                     cur_duty        <= nxt_duty;
                     comp_levels_out <= encode_duty(nxt_duty, maxcnt_l);
                  end else begin
                     dwell_cnt <= dwell_cnt + 16'd1;
                  end
               end else begin
                  period_cnt <= period_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: a table of fade commands with their
// expected config word, update edges/levels and done timing, followed by
// hand-written abort and reset sequences.
module tb_pwm_fade_ctrl;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_divval;
   logic [15:0] cmd_maxcnt;
   logic [15:0] cmd_target;
   logic [15:0] cmd_step;
   logic [15:0] cmd_dwell;
   logic        abort;
   logic [31:0] config_out;
   logic [31:0] comp_levels_out;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   pwm_fade_ctrl #(.CNT_W(34)) dut (
      .clk             (clk),
      .rst             (rst),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_divval      (cmd_divval),
      .cmd_maxcnt      (cmd_maxcnt),
      .cmd_target      (cmd_target),
      .cmd_step        (cmd_step),
      .cmd_dwell       (cmd_dwell),
      .abort           (abort),
      .config_out      (config_out),
      .comp_levels_out (comp_levels_out),
      .busy            (busy),
      .done            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One fade command and its expected outcome. done_at counts cycles after
   // the accept edge; n_upd level changes are taken in order from upd_tab.
   typedef struct {
      logic [15:0] divval;
      logic [15:0] maxcnt;
      logic [15:0] target;
      logic [15:0] step;
      logic [15:0] dwell;
      logic [31:0] exp_config;
      int          n_upd;
      int          done_at;
   } vec_t;

   // Expected comp_levels_out change: edge index after accept, new value.
   typedef struct {
      int          edge_k;
      logic [31:0] level;
   } upd_t;

   localparam int NV    = 8;
   localparam int NU    = 21;
   localparam int LIMIT = 300;

   vec_t vecs[NV];
   upd_t upd_tab[NU];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Offer a command at the falling edge; returns #1 after the accept edge.
   task automatic issue(input logic [15:0] d, input logic [15:0] m, input logic [15:0] t,
                        input logic [15:0] s, input logic [15:0] w);
      @(negedge clk);
      cmd_divval = d;
      cmd_maxcnt = m;
      cmd_target = t;
      cmd_step   = s;
      cmd_dwell  = w;
      cmd_valid  = 1'b1;
      #1;
      chk("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      cmd_valid  = 1'b0;
      // Later changes on cmd_* must have no effect.
      cmd_divval = 16'($urandom);
      cmd_maxcnt = 16'($urandom);
      cmd_target = 16'($urandom);
      cmd_step   = 16'($urandom);
      cmd_dwell  = 16'($urandom);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int          p;
      int          changes;
      int          done_k;
      int          seen;
      logic [31:0] prev;

      rst        = 1'b0;
      cmd_valid  = 1'b0;
      abort      = 1'b0;
      cmd_divval = '0;
      cmd_maxcnt = '0;
      cmd_target = '0;
      cmd_step   = '0;
      cmd_dwell  = '0;

      //            div     maxcnt     target     step   dwell  config        nupd done
      vecs[0] = '{16'd0, 16'd3,     16'd4,     16'd1, 16'd1, 32'h0003_0000, 4, 33};
      vecs[1] = '{16'd0, 16'd3,     16'd0,     16'd4, 16'd1, 32'h0003_0000, 1, 9};
      vecs[2] = '{16'd0, 16'd9,     16'd5,     16'd3, 16'd2, 32'h0009_0000, 2, 81};
      vecs[3] = '{16'd0, 16'd9,     16'd0,     16'd3, 16'd2, 32'h0009_0000, 2, 81};
      vecs[4] = '{16'd0, 16'd7,     16'h0020,  16'd0, 16'd0, 32'h0007_0000, 8, 129};
      vecs[5] = '{16'd1, 16'd1,     16'd1,     16'd8, 16'd1, 32'h0001_0001, 1, 9};
      vecs[6] = '{16'd0, 16'd3,     16'd1,     16'd1, 16'd1, 32'h0003_0000, 0, 1};
      vecs[7] = '{16'd0, 16'hFFFF,  16'd1,     16'd1, 16'd1, 32'hFFFE_0000, 0, 1};

      upd_tab[0]  = '{8,   32'h0000_0001};
      upd_tab[1]  = '{16,  32'h0000_0002};
      upd_tab[2]  = '{24,  32'h0000_0003};
      upd_tab[3]  = '{32,  32'h0000_FFFF};
      upd_tab[4]  = '{8,   32'hFFFF_0000};
      upd_tab[5]  = '{40,  32'h0000_0003};
      upd_tab[6]  = '{80,  32'h0000_0005};
      upd_tab[7]  = '{40,  32'h0000_0002};
      upd_tab[8]  = '{80,  32'hFFFF_0000};
      upd_tab[9]  = '{16,  32'h0000_0001};
      upd_tab[10] = '{32,  32'h0000_0002};
      upd_tab[11] = '{48,  32'h0000_0003};
      upd_tab[12] = '{64,  32'h0000_0004};
      upd_tab[13] = '{80,  32'h0000_0005};
      upd_tab[14] = '{96,  32'h0000_0006};
      upd_tab[15] = '{112, 32'h0000_0007};
      upd_tab[16] = '{128, 32'h0000_FFFF};
      upd_tab[17] = '{8,   32'h0000_0001};
      upd_tab[18] = '{0,   32'h0};
      upd_tab[19] = '{0,   32'h0};
      upd_tab[20] = '{0,   32'h0};

      // Asynchronous reset before any clock edge.
      #2;
      rst = 1'b1;
      #1;
      chk("rst_comp_levels", comp_levels_out, 32'hFFFF_0000);
      chk("rst_config", config_out, 32'h0000_0000);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven fade commands, each starting from the previous duty.
      p = 0;
      for (int i = 0; i < NV; i++) begin
         prev = comp_levels_out;
         issue(vecs[i].divval, vecs[i].maxcnt, vecs[i].target, vecs[i].step, vecs[i].dwell);
         chk($sformatf("v%0d_config", i), config_out, vecs[i].exp_config);
         chk($sformatf("v%0d_busy_start", i), 32'(busy), (vecs[i].n_upd > 0) ? 32'd1 : 32'd0);
         changes = 0;
         done_k  = -1;
         for (int k = 0; k < LIMIT; k++) begin
            if (k > 0) begin
               @(posedge clk);
               #1;
            end
            if (busy && done)
               chk($sformatf("v%0d_busy_done_overlap", i), 32'(busy & done), 32'd0);
            if (comp_levels_out !== prev) begin
               if (changes < vecs[i].n_upd) begin
                  chk($sformatf("v%0d_level%0d", i, changes), comp_levels_out,
                      upd_tab[p + changes].level);
                  chk($sformatf("v%0d_edge%0d", i, changes), 32'(k),
                      32'(upd_tab[p + changes].edge_k));
               end else begin
                  chk($sformatf("v%0d_extra_update", i), comp_levels_out, prev);
               end
               changes++;
               prev = comp_levels_out;
            end
            if (done) begin
               done_k = k + 1;
               break;
            end
         end
         chk($sformatf("v%0d_n_updates", i), 32'(changes), 32'(vecs[i].n_upd));
         chk($sformatf("v%0d_done_at", i), 32'(done_k), 32'(vecs[i].done_at));
         chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_done_width", i), 32'(done), 32'd0);
         chk($sformatf("v%0d_ready_after", i), 32'(cmd_ready), 32'd1);
         p += vecs[i].n_upd;
      end

      // Abort after the second update: duty holds at 2, no done.
      pulse_reset();
      issue(16'd0, 16'd3, 16'd4, 16'd1, 16'd1);
      repeat (16) @(posedge clk);
      #1;
      chk("abort_pre_level", comp_levels_out, 32'h0000_0002);
      chk("abort_pre_busy", 32'(busy), 32'd1);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(cmd_ready), 32'd1);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_level", comp_levels_out, 32'h0000_0002);
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (done || busy || comp_levels_out !== 32'h0000_0002) seen++;
      end
      chk("abort_held", 32'(seen), 32'd0);

      // Command whose target equals the held duty completes immediately.
      issue(16'd0, 16'd3, 16'd2, 16'd1, 16'd1);
      chk("noop_done", 32'(done), 32'd1);
      chk("noop_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk("noop_done_width", 32'(done), 32'd0);
      chk("noop_busy_after", 32'(busy), 32'd0);
      chk("noop_level", comp_levels_out, 32'h0000_0002);

      // Abort on the final update edge: completion wins.
      issue(16'd0, 16'd3, 16'd3, 16'd1, 16'd1);
      repeat (7) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_final_done", 32'(done), 32'd1);
      chk("abort_final_busy", 32'(busy), 32'd0);
      chk("abort_final_level", comp_levels_out, 32'h0000_0003);

      // Abort held during accept in IDLE is ignored; then reset mid-ramp.
      abort = 1'b1;
      issue(16'd0, 16'd3, 16'd0, 16'd1, 16'd1);
      abort = 1'b0;
      chk("idle_abort_ignored", 32'(busy), 32'd1);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_comp_levels", comp_levels_out, 32'hFFFF_0000);
      chk("midrst_config", config_out, 32'h0000_0000);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Fresh ramp after reset starts from duty 0.
      issue(16'd0, 16'd3, 16'd4, 16'd1, 16'd1);
      chk("post_rst_config", config_out, 32'h0003_0000);
      repeat (7) @(posedge clk);
      #1;
      chk("post_rst_before_update", comp_levels_out, 32'hFFFF_0000);
      @(posedge clk);
      #1;
      chk("post_rst_first_update", comp_levels_out, upd_tab[17].level);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
